// File: rtl/tsf_timer_alarm.sv
// Microsecond TSF timer with clock prescaler, falling-edge load, signed fine
// adjustment and NUM_ALARM independent sticky compare/alarm channels.
module tsf_timer_alarm #(
    parameter int unsigned TIMER_WIDTH = 64,
    parameter int unsigned CLK_DIV     = 200,
    parameter int unsigned ADJ_WIDTH   = 16,
    parameter int unsigned NUM_ALARM   = 4
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             tsf_load_control,
    input  logic [TIMER_WIDTH-1:0]           tsf_load_val,
    input  logic                             tsf_adj_en,
    input  logic [ADJ_WIDTH-1:0]             tsf_adj_val,
    input  logic [NUM_ALARM-1:0]             alarm_set,
    input  logic [NUM_ALARM-1:0]             alarm_clear,
    input  logic [NUM_ALARM*TIMER_WIDTH-1:0] alarm_val,
    output logic [TIMER_WIDTH-1:0]           tsf_runtime_val,
    output logic                             tsf_pulse_1M,
    output logic [NUM_ALARM-1:0]             alarm_armed,
    output logic [NUM_ALARM-1:0]             alarm_irq,
    output logic                             alarm_irq_any
);

    localparam int unsigned PRE_W = $clog2(CLK_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } ch_state_t;

    logic [PRE_W-1:0]       presc;
    logic                   load_q;
    logic                   load_edge_c;
    logic                   tick_c;
    logic [TIMER_WIDTH-1:0] adj_ext_c;
    logic [TIMER_WIDTH-1:0] tsf_nxt_c;

    ch_state_t              state     [NUM_ALARM];
    ch_state_t              state_nxt_c [NUM_ALARM];
    logic [TIMER_WIDTH-1:0] cmp       [NUM_ALARM];
    logic [NUM_ALARM-1:0]   irq_nxt_c;

    // A load edge resets the microsecond phase and suppresses the tick.
    assign load_edge_c = load_q & ~tsf_load_control;
    assign tick_c      = (presc == '0) & ~load_edge_c;
    assign adj_ext_c   = tsf_adj_en ? TIMER_WIDTH'($signed(tsf_adj_val)) : '0;
    assign tsf_nxt_c   = load_edge_c ? tsf_load_val
                                     : tsf_runtime_val + adj_ext_c + TIMER_WIDTH'(tick_c);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            presc           <= '0;
            load_q          <= 1'b0;
            tsf_runtime_val <= '0;
            tsf_pulse_1M    <= 1'b0;
        end else begin
            load_q          <= tsf_load_control;
            presc           <= (load_edge_c || presc == PRE_MAX) ? '0 : presc + PRE_W'(1);
            tsf_runtime_val <= tsf_nxt_c;
            tsf_pulse_1M    <= tick_c;
        end
    end

    // Per-channel next state: set beats clear, both beat a fire.
    always_comb begin
        irq_nxt_c = alarm_irq;
        for (int i = 0; i < NUM_ALARM; i++) begin
            state_nxt_c[i] = state[i];
            if (alarm_set[i]) begin
                state_nxt_c[i] = ARMED;
                irq_nxt_c[i]   = 1'b0;
            end else if (alarm_clear[i]) begin
                state_nxt_c[i] = IDLE;
                irq_nxt_c[i]   = 1'b0;
            end else if (state[i] == ARMED && tsf_runtime_val >= cmp[i]) begin
                state_nxt_c[i] = IDLE;
                irq_nxt_c[i]   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_ALARM; i++) begin
                state[i] <= IDLE;
                cmp[i]   <= '0;
            end
            alarm_irq     <= '0;
            alarm_irq_any <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ALARM; i++) begin
                state[i] <= state_nxt_c[i];
                if (alarm_set[i]) begin
                    cmp[i] <= alarm_val[i*TIMER_WIDTH +: TIMER_WIDTH];
                end
            end
            alarm_irq     <= irq_nxt_c;
            alarm_irq_any <= |irq_nxt_c;
        end
    end

    always_comb begin
        alarm_armed = '0;
        for (int i = 0; i < NUM_ALARM; i++) begin
            alarm_armed[i] = (state[i] == ARMED);
        end
    end

endmodule

// File: tb/tb_tsf_timer_alarm.sv
// Scoreboard bench for tsf_timer_alarm: a cycle-level reference model pushes
// expected outputs per cycle, a monitor pops and compares after each edge.
module tb_tsf_timer_alarm;

    localparam int unsigned TW = 16;
    localparam int unsigned CD = 5;
    localparam int unsigned AW = 12;
    localparam int unsigned NA = 3;
    localparam longint MASK = (longint'(1) << TW) - 1;

    logic               clk = 1'b0;
    logic               rstn;
    logic               tsf_load_control;
    logic [TW-1:0]      tsf_load_val;
    logic               tsf_adj_en;
    logic [AW-1:0]      tsf_adj_val;
    logic [NA-1:0]      alarm_set;
    logic [NA-1:0]      alarm_clear;
    logic [NA*TW-1:0]   alarm_val;
    logic [TW-1:0]      tsf_runtime_val;
    logic               tsf_pulse_1M;
    logic [NA-1:0]      alarm_armed;
    logic [NA-1:0]      alarm_irq;
    logic               alarm_irq_any;

    tsf_timer_alarm #(
        .TIMER_WIDTH (TW),
        .CLK_DIV     (CD),
        .ADJ_WIDTH   (AW),
        .NUM_ALARM   (NA)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .tsf_load_control (tsf_load_control),
        .tsf_load_val     (tsf_load_val),
        .tsf_adj_en       (tsf_adj_en),
        .tsf_adj_val      (tsf_adj_val),
        .alarm_set        (alarm_set),
        .alarm_clear      (alarm_clear),
        .alarm_val        (alarm_val),
        .tsf_runtime_val  (tsf_runtime_val),
        .tsf_pulse_1M     (tsf_pulse_1M),
        .alarm_armed      (alarm_armed),
        .alarm_irq        (alarm_irq),
        .alarm_irq_any    (alarm_irq_any)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint      tsf;
        bit          pulse;
        bit [NA-1:0] armed;
        bit [NA-1:0] irq;
        bit          any;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: time-based tick schedule rather than a prescaler.
    longint m_tsf = 0;
    bit     m_pulse = 0;
    bit     m_prev_lc = 0;
    int     cyc = 0;
    int     next_tick = 0;
    bit     m_armed [NA];
    bit     m_irq   [NA];
    longint m_cmp   [NA];

    task automatic model_step();
        exp_t   e;
        bit     edge_s;
        bit     tk;
        longint old_tsf;
        longint adj_s;
        if (!rstn) begin
            m_tsf = 0;
            m_pulse = 0;
            m_prev_lc = 0;
            next_tick = cyc + 1;
            for (int i = 0; i < NA; i++) begin
                m_armed[i] = 0;
                m_irq[i] = 0;
                m_cmp[i] = 0;
            end
        end else begin
            edge_s = m_prev_lc && !tsf_load_control;
            tk = !edge_s && (cyc == next_tick);
            old_tsf = m_tsf;
            adj_s = tsf_adj_en ? longint'($signed(tsf_adj_val)) : 0;
            if (edge_s) begin
                m_tsf = longint'(tsf_load_val);
                next_tick = cyc + 1;
            end else begin
                m_tsf = (m_tsf + adj_s + (tk ? 1 : 0)) & MASK;
                if (tk) next_tick = next_tick + CD;
            end
            m_pulse = tk;
            m_prev_lc = tsf_load_control;
            for (int i = 0; i < NA; i++) begin
                if (alarm_set[i]) begin
                    m_cmp[i] = longint'(alarm_val[i*TW +: TW]);
                    m_armed[i] = 1;
                    m_irq[i] = 0;
                end else if (alarm_clear[i]) begin
                    m_armed[i] = 0;
                    m_irq[i] = 0;
                end else if (m_armed[i] && old_tsf >= m_cmp[i]) begin
                    m_armed[i] = 0;
                    m_irq[i] = 1;
                end
            end
        end
        cyc++;
        e.tsf = m_tsf;
        e.pulse = m_pulse;
        e.any = 0;
        for (int i = 0; i < NA; i++) begin
            e.armed[i] = m_armed[i];
            e.irq[i] = m_irq[i];
            e.any = e.any | m_irq[i];
        end
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: outputs are valid every cycle, one expectation per edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("tsf", 64'(tsf_runtime_val), 64'(e.tsf));
                chk("pulse", 64'(tsf_pulse_1M), 64'(e.pulse));
                chk("armed", 64'(alarm_armed), 64'(e.armed));
                chk("irq", 64'(alarm_irq), 64'(e.irq));
                chk("irq_any", 64'(alarm_irq_any), 64'(e.any));
            end
        end
    end

    task automatic step();
        model_step();
        @(negedge clk);
        tsf_adj_en  = 1'b0;
        alarm_set   = '0;
        alarm_clear = '0;
    endtask

    task automatic do_load(input longint v);
        tsf_load_control = 1'b1;
        step();
        tsf_load_control = 1'b0;
        tsf_load_val = TW'(v);
        step();
    endtask

    task automatic set_alarm(input int ch, input longint v);
        alarm_val[ch*TW +: TW] = TW'(v);
        alarm_set[ch] = 1'b1;
    endtask

    initial begin
        int r;
        rstn = 1'b0;
        tsf_load_control = 1'b0;
        tsf_load_val = '0;
        tsf_adj_en = 1'b0;
        tsf_adj_val = '0;
        alarm_set = '0;
        alarm_clear = '0;
        alarm_val = '0;
        @(negedge clk);
        repeat (3) step();

        // Free run from reset release.
        rstn = 1'b1;
        repeat (31) step();

        // Falling-edge load.
        do_load(64'h1234);
        repeat (12) step();

        // Adjust coincident with a tick, then a positive one off-tick.
        do_load(1000);
        for (int k = 0; k < 2 * CD && cyc != next_tick; k++) step();
        tsf_adj_en = 1'b1;
        tsf_adj_val = AW'(-5);
        step();
        step();
        tsf_adj_en = 1'b1;
        tsf_adj_val = AW'(300);
        step();
        repeat (2 * CD) step();

        // Future alarm on channel 2, then clear.
        set_alarm(2, m_tsf + 16);
        step();
        repeat (18 * CD) step();
        alarm_clear[2] = 1'b1;
        step();
        step();

        // Past value fires two cycles after set.
        set_alarm(0, 10);
        repeat (3) step();
        // Set and clear together: set wins.
        set_alarm(1, m_tsf + 1000);
        alarm_clear[1] = 1'b1;
        repeat (3) step();
        alarm_clear[1] = 1'b1;
        step();
        // Clear on the would-be fire cycle keeps irq low.
        set_alarm(0, 5);
        step();
        alarm_clear[0] = 1'b1;
        step();
        repeat (2) step();

        // Wrap through all-ones, then alarm at 1 after wrap.
        do_load(MASK - 1);
        for (int k = 0; k < 4 * CD && m_tsf != 0; k++) step();
        set_alarm(1, 1);
        repeat (3 * CD) step();

        // Backward load after fire must not re-trigger.
        do_load(0);
        repeat (3 * CD) step();

        // Reset mid-operation with strobes active.
        set_alarm(0, 0);
        tsf_adj_en = 1'b1;
        tsf_adj_val = AW'(7);
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        repeat (3) step();

        // Randomized traffic.
        repeat (3000) begin
            if ($urandom_range(0, 30) == 0) tsf_load_control = ~tsf_load_control;
            if ($urandom_range(0, 7) == 0)
                tsf_load_val = ($urandom_range(0, 3) == 0) ? TW'(MASK - longint'($urandom_range(0, 20)))
                                                           : TW'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                tsf_adj_en = 1'b1;
                tsf_adj_val = AW'($urandom);
            end
            for (int i = 0; i < NA; i++) begin
                r = $urandom_range(0, 39);
                if (r == 0 || r == 2)
                    set_alarm(i, (m_tsf + longint'($urandom_range(0, 60)) - 10) & MASK);
                if (r == 1 || r == 2) alarm_clear[i] = 1'b1;
            end
            rstn = ($urandom_range(0, 499) != 0);
            step();
        end
        rstn = 1'b1;
        tsf_load_control = 1'b0;
        repeat (5) step();
        repeat (3) @(posedge clk);
        #2;
        chk("drain", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
